// File: rtl/alu_decoder_pkg.sv
// Shared RV32I opcode constants, ALU function codes and the decoded bundle.
// The ALU imports the same package so both sides agree on the fop encoding.
package alu_decoder_pkg;

    typedef enum logic [3:0] {
        FOP_ADD = 4'd0,
        FOP_SUB = 4'd1,
        FOP_SLL = 4'd2,
        FOP_SRL = 4'd3,
        FOP_SRA = 4'd4,
        FOP_AND = 4'd5,
        FOP_OR  = 4'd6,
        FOP_XOR = 4'd7,
        FOP_IMM = 4'd8
    } fop_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef struct packed {
        fop_e        fop;
        logic [31:0] imm_gen;
        logic        alu_mux_en;
        logic        u;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        reg_write;
        logic        illegal;
    } dec_t;

endpackage

// File: rtl/imm_gen_unit.sv
// Combinational RV32I immediate generator for the formats the decoder uses.
// OP-IMM shifts take a zero-extended shamt instead of the sign-extended I-imm.
module imm_gen_unit
    import alu_decoder_pkg::*;
(
    input  logic [31:0] instr,
    output logic [31:0] imm_gen
);

    logic [6:0]  opc;
    logic [2:0]  f3;
    logic        is_shift;
    logic [31:0] i_imm;
    logic [31:0] s_imm;
    logic [31:0] b_imm;
    logic [31:0] u_imm;

    assign opc      = instr[6:0];
    assign f3       = instr[14:12];
    assign is_shift = (f3 == 3'b001) || (f3 == 3'b101);

    assign i_imm = {{20{instr[31]}}, instr[31:20]};
    assign s_imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign b_imm = {{19{instr[31]}}, instr[31], instr[7],
                    instr[30:25], instr[11:8], 1'b0};
    assign u_imm = {instr[31:12], 12'b0};

    always_comb begin
        imm_gen = '0;
        case (opc)
            OPC_OP_IMM: imm_gen = is_shift ? {27'b0, instr[24:20]} : i_imm;
            OPC_LOAD:   imm_gen = i_imm;
            OPC_STORE:  imm_gen = s_imm;
            OPC_BRANCH: imm_gen = b_imm;
            OPC_LUI:    imm_gen = u_imm;
            default:    imm_gen = '0;
        endcase
    end

endmodule

// File: rtl/alu_decoder.sv
// RV32I integer decoder feeding the ALU stage through a one-deep
// valid/ready output register, with a saturating illegal-instruction count.
module alu_decoder
    import alu_decoder_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] instr,
    output logic        in_ready,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  fop,
    output logic [31:0] imm_gen,
    output logic        alu_mux_en,
    output logic        u,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rd,
    output logic        reg_write,
    output logic        illegal,
    output logic [7:0]  illegal_count
);

    logic [31:0] imm_raw;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic        f7_base;
    logic        f7_alt;
    logic        bad;
    logic        accept;
    dec_t        dec;
    dec_t        q;
    logic        valid_q;
    logic [7:0]  cnt;

    imm_gen_unit u_imm_gen (
        .instr   (instr),
        .imm_gen (imm_raw)
    );

    assign opc     = instr[6:0];
    assign f3      = instr[14:12];
    assign f7_base = (instr[31:25] == F7_BASE);
    assign f7_alt  = (instr[31:25] == F7_ALT);

    always_comb begin
        dec     = '0;
        dec.rs1 = instr[19:15];
        dec.rs2 = instr[24:20];
        dec.rd  = instr[11:7];
        bad     = 1'b0;
        case (opc)
            OPC_OP: begin
                dec.reg_write = 1'b1;
                case (f3)
                    3'b000: begin
                        dec.fop = f7_alt ? FOP_SUB : FOP_ADD;
                        bad     = !(f7_base || f7_alt);
                    end
                    3'b001: begin dec.fop = FOP_SLL; bad = !f7_base; end
                    3'b010: begin dec.fop = FOP_SUB; bad = !f7_base; end
                    3'b011: begin
                        dec.fop = FOP_SUB;
                        dec.u   = 1'b1;
                        bad     = !f7_base;
                    end
                    3'b100: begin dec.fop = FOP_XOR; bad = !f7_base; end
                    3'b101: begin
                        dec.fop = f7_alt ? FOP_SRA : FOP_SRL;
                        bad     = !(f7_base || f7_alt);
                    end
                    3'b110: begin dec.fop = FOP_OR;  bad = !f7_base; end
                    default: begin dec.fop = FOP_AND; bad = !f7_base; end
                endcase
            end
            OPC_OP_IMM: begin
                dec.reg_write  = 1'b1;
                dec.alu_mux_en = 1'b1;
                case (f3)
                    3'b000: dec.fop = FOP_ADD;
                    3'b001: begin dec.fop = FOP_SLL; bad = !f7_base; end
                    3'b010: dec.fop = FOP_SUB;
                    3'b011: begin dec.fop = FOP_SUB; dec.u = 1'b1; end
                    3'b100: dec.fop = FOP_XOR;
                    3'b101: begin
                        dec.fop = f7_alt ? FOP_SRA : FOP_SRL;
                        bad     = !(f7_base || f7_alt);
                    end
                    3'b110: dec.fop = FOP_OR;
                    default: dec.fop = FOP_AND;
                endcase
            end
            OPC_LOAD: begin
                dec.fop        = FOP_ADD;
                dec.alu_mux_en = 1'b1;
                dec.reg_write  = 1'b1;
                bad = (f3 == 3'b011) || (f3[2:1] == 2'b11);
            end
            OPC_STORE: begin
                dec.fop        = FOP_ADD;
                dec.alu_mux_en = 1'b1;
                bad            = (f3 > 3'b010);
            end
            OPC_BRANCH: begin
                dec.fop = FOP_SUB;
                dec.u   = f3[2] & f3[1];
                bad     = (f3[2:1] == 2'b01);
            end
            OPC_LUI: begin
                dec.fop       = FOP_IMM;
                dec.reg_write = 1'b1;
            end
            default: bad = 1'b1;
        endcase
        dec.imm_gen = imm_raw;
        if (dec.rd == 5'd0) dec.reg_write = 1'b0;
        // Illegal bundles travel down as a harmless ADD with no writeback.
        if (bad) begin
            dec.fop        = FOP_ADD;
            dec.imm_gen    = '0;
            dec.alu_mux_en = 1'b0;
            dec.u          = 1'b0;
            dec.reg_write  = 1'b0;
            dec.illegal    = 1'b1;
        end
    end

    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            q       <= '0;
            cnt     <= '0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (accept) begin
            valid_q <= 1'b1;
            q       <= dec;
            if (dec.illegal && cnt != 8'hFF) cnt <= cnt + 8'd1;
        end else if (out_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign out_valid     = valid_q;
    assign fop           = q.fop;
    assign imm_gen       = q.imm_gen;
    assign alu_mux_en    = q.alu_mux_en;
    assign u             = q.u;
    assign rs1           = q.rs1;
    assign rs2           = q.rs2;
    assign rd            = q.rd;
    assign reg_write     = q.reg_write;
    assign illegal       = q.illegal;
    assign illegal_count = cnt;

endmodule

// File: doc/alu_decoder.md
ALU_DECODER -- requirements
Module: alu_decoder

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state rises on posedge.
REQ-002 SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-003 SHALL have port in_valid, input, 1, instr holds a new instruction.
REQ-004 SHALL have port instr, input, 32, RV32I instruction word.
REQ-005 SHALL have port in_ready, output, 1, decoder accepts instr this cycle.
REQ-006 SHALL have port flush, input, 1, discard held output.
REQ-007 SHALL have port out_valid, output, 1, decoded bundle valid.
REQ-008 SHALL have port out_ready, input, 1, downstream ALU stage consumes bundle.
REQ-009 SHALL have port fop, output, 4, ALU function code.
REQ-010 SHALL have port imm_gen, output, 32, generated immediate.
REQ-011 SHALL have ports alu_mux_en and u, output, 1 each: select imm_gen as ALU operand b; unsigned compare operands.
REQ-012 SHALL have ports rs1, rs2, rd, output, 5 each, register addresses.
REQ-013 SHALL have ports reg_write and illegal, output, 1 each.
REQ-014 SHALL have port illegal_count, output, 8, saturating illegal-instruction counter.

Function
REQ-015 SHALL encode fop as ADD=0, SUB=1, SLL=2, SRL=3, SRA=4, AND=5, OR=6, XOR=7, IMM=8.
REQ-016 SHALL capture a transfer when in_valid && in_ready; outputs update on the next posedge (latency 1).
REQ-017 SHALL drive in_ready = !out_valid || out_ready (combinational, no dependency on in_valid).
REQ-018 SHALL hold all outputs stable while out_valid && !out_ready.
REQ-019 SHALL clear out_valid when out_ready && !(in_valid && in_ready).
REQ-020 SHALL, on flush, clear out_valid next edge and ignore any same-cycle input transfer; flush wins over every other event.
REQ-021 SHALL decode OP (0110011): funct3/funct7 to ADD, SUB(f7=0100000), SLL, SRL, SRA(f7=0100000), AND, OR, XOR; SLT -> SUB u=0; SLTU -> SUB u=1; alu_mux_en=0; reg_write=1.
REQ-022 SHALL decode OP-IMM (0010011) likewise with alu_mux_en=1; no SUBI; shift imm = zero-extended instr[24:20]; SLLI/SRLI/SRAI with bad funct7 -> illegal.
REQ-023 SHALL decode LOAD (0000011) as ADD, I-imm, alu_mux_en=1, reg_write=1; STORE (0100011) as ADD, S-imm, alu_mux_en=1, reg_write=0.
REQ-024 SHALL decode BRANCH (1100011) as SUB, B-imm, alu_mux_en=0, reg_write=0; u=1 for BLTU/BGEU, else 0; funct3 010/011 -> illegal.
REQ-025 SHALL decode LUI (0110111) as IMM with imm_gen = {instr[31:12], 12'b0}, reg_write=1.
REQ-026 SHALL sign-extend I/S/B immediates from instr[31]; B-imm bit 0 = 0.
REQ-027 SHALL treat any other opcode or undefined funct combination as illegal: illegal=1, fop=ADD, imm_gen=0, alu_mux_en=0, u=0, reg_write=0; out_valid still asserted.
REQ-028 SHALL increment illegal_count once per accepted illegal instruction, saturating at 255 (no wrap).
REQ-029 SHALL force reg_write=0 when rd=0.

Reset
REQ-030 SHALL, on rst, immediately set out_valid=0, illegal_count=0, fop=ADD, imm_gen=0, all other outputs 0; in_ready thus 1.
REQ-031 SHALL, on rst mid-stall, drop the held bundle without output and accept input on the first edge after rst deasserts.

Structure
REQ-032 SHALL take the fop enumeration and RV32I opcode constants from a shared package also used by ALU.
REQ-033 SHALL place immediate generation in sub-module imm_gen_unit (instr in, imm_gen out, combinational).

Verification
REQ-034 SHALL test instr=0x00500093 (addi x1,x0,5) -> next cycle out_valid=1, fop=0, imm_gen=5, alu_mux_en=1, rd=1, reg_write=1.
REQ-035 SHALL test instr=0x40208133 (sub x2,x1,x2) with out_ready=0 for 3 cycles -> bundle fop=1 held stable, in_ready=0, new input not taken.
REQ-036 SHALL test instr=0x0020E463 (bltu x1,x2,+8) -> fop=1, u=1, imm_gen=8, reg_write=0; instr=0xFE000EE3 -> imm_gen=0xFFFFF000-range sign-extended negative value checked against model.
REQ-037 SHALL test 300 accepted instr=0xFFFFFFFF -> illegal=1 each, illegal_count saturates at 255.
REQ-038 SHALL test flush asserted with in_valid=1 and out_valid=1 -> out_valid=0 next cycle, input dropped.
REQ-039 SHALL test rst asserted mid-stall -> out_valid=0 asynchronously, illegal_count=0.
